// File: rtl/sump_cmd_decoder_pkg.sv
// sump_cmd_pkg: opcode constants, state encoding and sizes for the SUMP command decoder
package sump_cmd_pkg;
    localparam logic [7:0] CMD_RESET  = 8'h00;
    localparam logic [7:0] CMD_ARM    = 8'h01;
    localparam logic [7:0] CMD_ID     = 8'h02;
    localparam logic [7:0] CMD_META   = 8'h04;
    localparam logic [7:0] CMD_FINISH = 8'h05;
    localparam logic [7:0] CMD_XON    = 8'h11;
    localparam logic [7:0] CMD_XOFF   = 8'h13;
    localparam int LONG_CMD_BYTES = 4;
    typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: assembles 1-byte and 5-byte SUMP commands into a registered opcode/data pair plus strobes
module sump_cmd_decoder
    import sump_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W = 17
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        cmd_valid,
    output logic [7:0]  opcode,
    output logic [31:0] cmd_data,
    output logic        soft_reset,
    output logic        arm,
    output logic        query_id,
    output logic        query_metadata,
    output logic        finish_now,
    output logic        xoff,
    output logic        timeout_err,
    output logic        busy
);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAST_SLOT = 2'(LONG_CMD_BYTES - 1);

    state_t                 state, state_n;
    logic [1:0]             cnt;
    logic [TIMEOUT_W-1:0]   tcnt;
    logic [7:0]             pend_op;
    logic [23:0]            pend_data;
    logic                   done, done_long, tmo;
    logic [7:0]             done_op;

    assign busy = (state == COLLECT);

    // state register
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) state <= IDLE;
        else          state <= state_n;
    end

    // next state: a long opcode opens COLLECT; the last data byte or an expired gap closes it
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = (rx_valid && rx_byte[7]) ? COLLECT : IDLE;
        else               state_n = (done || tmo) ? IDLE : COLLECT;
    end

    // completion and timeout decode; a byte arriving on the expiry cycle suppresses the timeout
    always_comb begin
        done_long = (state == COLLECT) && rx_valid && (cnt == LAST_SLOT);
        done      = done_long || ((state == IDLE) && rx_valid && !rx_byte[7]);
        done_op   = (state == IDLE) ? rx_byte : pend_op;
        tmo       = (state == COLLECT) && !rx_valid && (tcnt == TMO_LAST);
    end

    // pending command: opcode, little-endian data slots, byte index and inter-byte gap counter
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            pend_op   <= '0;
            pend_data <= '0;
            cnt       <= '0;
            tcnt      <= '0;
        end else if (state == IDLE) begin
            if (rx_valid && rx_byte[7]) begin
                pend_op   <= rx_byte;
                pend_data <= '0;
                cnt       <= '0;
                tcnt      <= '0;
            end
        end else if (rx_valid) begin
            if (cnt != LAST_SLOT) pend_data[{cnt, 3'b000} +: 8] <= rx_byte;
            cnt  <= cnt + 2'd1;
            tcnt <= '0;
        end else if (tmo) begin
            pend_op   <= '0;
            pend_data <= '0;
            cnt       <= '0;
            tcnt      <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // registered command outputs, one-cycle strobes and the xoff level
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            cmd_valid      <= 1'b0;
            opcode         <= '0;
            cmd_data       <= '0;
            soft_reset     <= 1'b0;
            arm            <= 1'b0;
            query_id       <= 1'b0;
            query_metadata <= 1'b0;
            finish_now     <= 1'b0;
            xoff           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            cmd_valid      <= done;
            soft_reset     <= done && (done_op == CMD_RESET);
            arm            <= done && (done_op == CMD_ARM);
            query_id       <= done && (done_op == CMD_ID);
            query_metadata <= done && (done_op == CMD_META);
            finish_now     <= done && (done_op == CMD_FINISH);
            timeout_err    <= tmo;
            if (done) opcode <= done_op;
            if (done_long) cmd_data <= {rx_byte, pend_data};
            if (done && (done_op == CMD_XOFF)) xoff <= 1'b1;
            else if (done && (done_op == CMD_XON || done_op == CMD_RESET)) xoff <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// tb_sump_cmd_decoder: directed self-checking bench for the SUMP command decoder
module tb_sump_cmd_decoder;
    logic        clock = 1'b0;
    logic        extReset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cmd_valid, soft_reset, arm, query_id, query_metadata, finish_now, xoff, timeout_err, busy;
    logic [7:0]  opcode;
    logic [31:0] cmd_data;
    int          n_pass = 0;
    int          n_total = 0;
    int          busy_cnt;

    sump_cmd_decoder #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
        .clock(clock), .extReset(extReset), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cmd_valid(cmd_valid), .opcode(opcode), .cmd_data(cmd_data),
        .soft_reset(soft_reset), .arm(arm), .query_id(query_id), .query_metadata(query_metadata),
        .finish_now(finish_now), .xoff(xoff), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        @(negedge clock);
        rx_valid = v;
        rx_byte  = b;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_xoff", 32'(xoff), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        extReset = 1'b0;

        drive(1, 8'h04); drive(0, 8'h00);
        chk("meta_cmd_valid", 32'(cmd_valid), 1);
        chk("meta_opcode", 32'(opcode), 32'h04);
        chk("meta_strobe", 32'(query_metadata), 1);
        chk("meta_cmd_data", cmd_data, 0);
        chk("meta_no_arm", 32'(arm), 0);
        drive(0, 8'h00);
        chk("meta_strobe_one_cycle", 32'(query_metadata), 0);
        chk("meta_cmd_valid_one_cycle", 32'(cmd_valid), 0);

        busy_cnt = 0;
        drive(1, 8'hC0);
        chk("long_busy_before", 32'(busy), 0);
        drive(1, 8'h78); busy_cnt += int'(busy);
        drive(1, 8'h56); busy_cnt += int'(busy);
        drive(1, 8'h34); busy_cnt += int'(busy);
        drive(1, 8'h12); busy_cnt += int'(busy);
        chk("long_no_early_valid", 32'(cmd_valid), 0);
        drive(0, 8'h00); busy_cnt += int'(busy);
        chk("long_busy_cycles", 32'(busy_cnt), 4);
        chk("long_cmd_valid", 32'(cmd_valid), 1);
        chk("long_opcode", 32'(opcode), 32'hC0);
        chk("long_cmd_data", cmd_data, 32'h12345678);
        drive(0, 8'h00);
        chk("long_cmd_valid_one_cycle", 32'(cmd_valid), 0);

        drive(1, 8'h13); drive(0, 8'h00);
        chk("xoff_set", 32'(xoff), 1);
        chk("xoff_opcode", 32'(opcode), 32'h13);
        drive(1, 8'h01); drive(0, 8'h00);
        chk("arm_strobe", 32'(arm), 1);
        chk("xoff_kept_by_arm", 32'(xoff), 1);
        drive(1, 8'h11); drive(0, 8'h00);
        chk("xoff_cleared_by_xon", 32'(xoff), 0);
        drive(1, 8'h13); drive(0, 8'h00);
        chk("xoff_set_again", 32'(xoff), 1);
        drive(1, 8'h00); drive(0, 8'h00);
        chk("soft_reset_strobe", 32'(soft_reset), 1);
        chk("xoff_cleared_by_reset", 32'(xoff), 0);
        chk("short_keeps_cmd_data", cmd_data, 32'h12345678);
        drive(1, 8'h7F); drive(0, 8'h00);
        chk("unknown_cmd_valid", 32'(cmd_valid), 1);
        chk("unknown_opcode", 32'(opcode), 32'h7F);
        chk("unknown_no_strobe", 32'({soft_reset, arm, query_id, query_metadata, finish_now}), 0);
        drive(1, 8'h00); drive(0, 8'h00);

        drive(1, 8'h81); drive(1, 8'hAA); drive(0, 8'h00);
        repeat (15) @(negedge clock);
        chk("tmo_not_yet", 32'(timeout_err), 0);
        chk("tmo_busy_before", 32'(busy), 1);
        @(negedge clock);
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_busy_after", 32'(busy), 0);
        chk("tmo_no_cmd_valid", 32'(cmd_valid), 0);
        chk("tmo_opcode_kept", 32'(opcode), 32'h00);
        chk("tmo_cmd_data_kept", cmd_data, 32'h12345678);
        @(negedge clock);
        chk("tmo_err_one_cycle", 32'(timeout_err), 0);
        drive(1, 8'h02); drive(0, 8'h00);
        chk("id_after_tmo", 32'(query_id), 1);
        chk("id_opcode", 32'(opcode), 32'h02);

        drive(1, 8'h83); drive(1, 8'h01); drive(0, 8'h00);
        repeat (14) @(negedge clock);
        drive(1, 8'h02);
        drive(1, 8'h03);
        chk("byte_wins_no_tmo", 32'(timeout_err), 0);
        chk("byte_wins_busy", 32'(busy), 1);
        drive(1, 8'h04); drive(0, 8'h00);
        chk("byte_wins_cmd_valid", 32'(cmd_valid), 1);
        chk("byte_wins_opcode", 32'(opcode), 32'h83);
        chk("byte_wins_cmd_data", cmd_data, 32'h04030201);

        drive(1, 8'h80); drive(1, 8'h00); drive(1, 8'h00); drive(1, 8'h00); drive(1, 8'h00);
        drive(1, 8'h04);
        chk("b2b_first_valid", 32'(cmd_valid), 1);
        chk("b2b_first_opcode", 32'(opcode), 32'h80);
        chk("b2b_first_data", cmd_data, 0);
        drive(0, 8'h00);
        chk("b2b_second_valid", 32'(cmd_valid), 1);
        chk("b2b_second_opcode", 32'(opcode), 32'h04);
        chk("b2b_second_meta", 32'(query_metadata), 1);

        drive(1, 8'h82); drive(1, 8'h11); drive(0, 8'h00);
        chk("mid_busy", 32'(busy), 1);
        #2 extReset = 1'b1;
        #1 chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_cmd_valid", 32'(cmd_valid), 0);
        @(negedge clock);
        extReset = 1'b0;
        drive(1, 8'h05); drive(0, 8'h00);
        chk("finish_strobe", 32'(finish_now), 1);
        chk("finish_opcode", 32'(opcode), 32'h05);
        chk("finish_cmd_data_clean", cmd_data, 0);
        drive(0, 8'h00);
        chk("no_stale_cmd_valid", 32'(cmd_valid), 0);
        chk("idle_after_reset", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
